// File: rtl/fft_frame_ctrl.sv
// Frame controller between an ADC sample stream and a streaming FFT core:
// frames samples into packets, waits for the FFT output frame, then idles before the next frame.
module fft_frame_ctrl #(
   parameter int unsigned FRAME_LEN = 2048,
   parameter int unsigned DW        = 16,
   parameter int unsigned HOLDOFF   = 1000,
   parameter int unsigned TIMEOUT   = 65535
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   input  logic          sample_en,
   input  logic [DW-1:0] adc_data,
   input  logic          fft_ready,
   input  logic          opd_o,
   input  logic [10:0]   idx_o,
   input  logic          err_clr,
   output logic [DW-1:0] fft_data,
   output logic          fft_valid,
   output logic          fft_sop,
   output logic          fft_eop,
   output logic          fft_clr,
   output logic          frame_done,
   output logic          busy,
   output logic          overrun_err,
   output logic          timeout_err,
   output logic [15:0]   frame_cnt
);

   localparam int unsigned CW = $clog2(FRAME_LEN);
   localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FEED     = 3'd1,
      S_WAIT_OUT = 3'd2,
      S_DRAIN    = 3'd3,
      S_HOLD     = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [DW-1:0]   data_q, data_d;
   logic            valid_q, valid_d;
   logic            sop_q, sop_d;
   logic            eop_q, eop_d;
   logic            clr_q, clr_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;
   logic            ovr_q, ovr_d;
   logic            terr_q, terr_d;
   logic [15:0]     fcnt_q, fcnt_d;
   logic            ovr_set, terr_set;

   // Bin index is informational only; nothing in the control path depends on it.
   logic unused_idx;
   assign unused_idx = ^idx_o;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tmo_d    = tmo_q;
      hold_d   = hold_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      sop_d    = 1'b0;
      eop_d    = 1'b0;
      clr_d    = 1'b0;
      done_d   = 1'b0;
      fcnt_d   = fcnt_q;
      ovr_set  = 1'b0;
      terr_set = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (run) begin
               state_d = S_FEED;
               cnt_d   = '0;
            end
         end
         S_FEED: begin
            if (sample_en) begin
               if (fft_ready) begin
                  valid_d = 1'b1;
                  data_d  = adc_data;
                  sop_d   = (cnt_q == '0);
                  eop_d   = (cnt_q == LAST);
                  if (cnt_q == LAST) begin
                     cnt_d   = '0;
                     tmo_d   = '0;
                     state_d = S_WAIT_OUT;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end else begin
                  // Sink stalled: the frame is unrecoverable, flush the core and restart.
                  ovr_set = 1'b1;
                  clr_d   = 1'b1;
                  cnt_d   = '0;
                  hold_d  = '0;
                  state_d = S_HOLD;
               end
            end
         end
         S_WAIT_OUT: begin
            if (opd_o) begin
               state_d = S_DRAIN;
            end else if ((32'(tmo_q) + 32'd1) >= TIMEOUT) begin
               terr_set = 1'b1;
               clr_d    = 1'b1;
               tmo_d    = '0;
               hold_d   = '0;
               state_d  = S_HOLD;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_DRAIN: begin
            if (!opd_o) begin
               done_d  = 1'b1;
               fcnt_d  = fcnt_q + 16'd1;
               hold_d  = '0;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (hold_q == HW'(HOLDOFF)) begin
               hold_d  = '0;
               cnt_d   = '0;
               state_d = run ? S_FEED : S_IDLE;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            tmo_d   = '0;
            hold_d  = '0;
         end
      endcase

      // A new error in the clearing cycle takes priority over the clear.
      ovr_d  = ovr_set  | (ovr_q  & ~err_clr);
      terr_d = terr_set | (terr_q & ~err_clr);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         tmo_q   <= '0;
         hold_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         clr_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
         terr_q  <= 1'b0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         hold_q  <= hold_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
         clr_q   <= clr_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         ovr_q   <= ovr_d;
         terr_q  <= terr_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign fft_data    = data_q;
   assign fft_valid   = valid_q;
   assign fft_sop     = sop_q;
   assign fft_eop     = eop_q;
   assign fft_clr     = clr_q;
   assign frame_done  = done_q;
   assign busy        = busy_q;
   assign overrun_err = ovr_q;
   assign timeout_err = terr_q;
   assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with FRAME_LEN=8, HOLDOFF=4, TIMEOUT=20.
module tb_fft_frame_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic        sample_en = 1'b0;
   logic [15:0] adc_data = '0;
   logic        fft_ready = 1'b1;
   logic        opd_o = 1'b0;
   logic [10:0] idx_o = '0;
   logic        err_clr = 1'b0;
   logic [15:0] fft_data;
   logic        fft_valid, fft_sop, fft_eop, fft_clr;
   logic        frame_done, busy, overrun_err, timeout_err;
   logic [15:0] frame_cnt;

   int n_vec = 0;
   int n_err = 0;
   int clr_n = 0;
   logic [17:0] vq[$];

   fft_frame_ctrl #(.FRAME_LEN(8), .DW(16), .HOLDOFF(4), .TIMEOUT(20)) dut (
      .clk(clk), .rst(rst), .run(run), .sample_en(sample_en), .adc_data(adc_data),
      .fft_ready(fft_ready), .opd_o(opd_o), .idx_o(idx_o), .err_clr(err_clr),
      .fft_data(fft_data), .fft_valid(fft_valid), .fft_sop(fft_sop), .fft_eop(fft_eop),
      .fft_clr(fft_clr), .frame_done(frame_done), .busy(busy),
      .overrun_err(overrun_err), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   // Log every sink beat as {sop, eop, data} and count core-clear pulses.
   always @(posedge clk) begin
      #1;
      if (fft_valid) vq.push_back({fft_sop, fft_eop, fft_data});
      if (fft_clr) clr_n++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return fft_eop & fft_valid;
         1:       return frame_done;
         2:       return fft_clr;
         default: return fft_sop & fft_valid;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int sel, input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sig(sel) && n < budget);
      chk({tag, "_seen"}, 64'(sig(sel)), 64'd1);
   endtask

   task automatic send(input logic [15:0] d, input logic rdy, input logic clr);
      repeat (3) @(negedge clk);
      sample_en = 1'b1; adc_data = d; fft_ready = rdy; err_clr = clr;
      @(negedge clk);
      sample_en = 1'b0; fft_ready = 1'b1; err_clr = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run still active, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int c0;
      logic [17:0] e;
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_data",  64'(fft_data), 64'd0);
      chk("rst_flags", 64'({fft_valid, fft_sop, fft_eop, fft_clr, frame_done, busy}), 64'd0);
      chk("rst_errs",  64'({overrun_err, timeout_err}), 64'd0);
      chk("rst_fcnt",  64'(frame_cnt), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);

      // Nominal frame: data 1..8, one strobe every 4th cycle
      run = 1'b1;
      @(negedge clk);
      chk("feed_busy", 64'(busy), 64'd1);
      vq.delete();
      for (int i = 1; i <= 8; i++) send(16'(i), 1'b1, 1'b0);
      chk("nom_eop", 64'({fft_valid, fft_eop}), 64'h3);
      chk("nom_len", 64'(vq.size()), 64'd8);
      for (int i = 0; i < vq.size() && i < 8; i++) begin
         e = {(i == 0), (i == 7), 16'(i + 1)};
         chk($sformatf("nom_beat%0d", i), 64'(vq[i]), 64'(e));
      end
      repeat (3) @(negedge clk);
      opd_o = 1'b1;
      repeat (8) @(negedge clk);
      opd_o = 1'b0;
      @(negedge clk);
      chk("nom_done", 64'(frame_done), 64'd1);
      chk("nom_fcnt", 64'(frame_cnt), 64'd1);

      // Strobes held high through HOLD are ignored; sop lands 6 cycles after done
      sample_en = 1'b1; adc_data = 16'h0B0B;
      vq.delete();
      wait_for("hold_sop", 3, 20, n);
      chk("hold_gap", 64'(n), 64'd6);
      chk("hold_ign", 64'(vq.size()), 64'd1);
      chk("done_pulse", 64'(frame_done), 64'd0);

      // Timeout: no FFT output after eop
      c0 = clr_n;
      wait_for("to_eop", 0, 20, n);
      chk("to_feed_len", 64'(n), 64'd7);
      wait_for("to_clr", 2, 40, n);
      chk("to_delay", 64'(n), 64'd20);
      chk("to_err", 64'(timeout_err), 64'd1);
      chk("to_fcnt", 64'(frame_cnt), 64'd1);
      chk("to_novalid", 64'(vq.size()), 64'd8);
      sample_en = 1'b0;
      @(negedge clk);
      chk("to_clr_pulse", 64'(fft_clr), 64'd0);
      chk("to_clr_cnt", 64'(clr_n - c0), 64'd1);
      chk("to_sticky", 64'(timeout_err), 64'd1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("to_errclr", 64'(timeout_err), 64'd0);

      // Overrun on the 5th strobe
      repeat (8) @(negedge clk);
      vq.delete();
      c0 = clr_n;
      for (int i = 1; i <= 4; i++) send(16'(i), 1'b1, 1'b0);
      send(16'd5, 1'b0, 1'b0);
      chk("ovr_clr", 64'(fft_clr), 64'd1);
      chk("ovr_err", 64'(overrun_err), 64'd1);
      chk("ovr_drop", 64'(fft_valid), 64'd0);
      chk("ovr_len", 64'(vq.size()), 64'd4);
      @(negedge clk);
      chk("ovr_clr_cnt", 64'(clr_n - c0), 64'd1);
      chk("ovr_hold_busy", 64'(busy), 64'd1);
      repeat (3) @(negedge clk);
      vq.delete();
      send(16'h0011, 1'b1, 1'b1);
      chk("ovr_errclr", 64'(overrun_err), 64'd0);
      chk("ovr_fresh_sop", 64'(vq.size() > 0 ? vq[0] : 18'h0), 64'({2'b10, 16'h0011}));
      send(16'h0012, 1'b0, 1'b1);
      chk("ovr_set_wins", 64'(overrun_err), 64'd1);
      chk("ovr_clr2", 64'(fft_clr), 64'd1);
      repeat (8) @(negedge clk);

      // run dropped after 3rd sample: frame completes, then IDLE
      vq.delete();
      for (int i = 1; i <= 3; i++) send(16'(16'h20 + i), 1'b1, 1'b0);
      run = 1'b0;
      for (int i = 4; i <= 8; i++) send(16'(16'h20 + i), 1'b1, 1'b0);
      chk("rd_eop", 64'({fft_valid, fft_eop}), 64'h3);
      chk("rd_len", 64'(vq.size()), 64'd8);
      chk("rd_first", 64'(vq.size() > 0 ? vq[0] : 18'h0), 64'({2'b10, 16'h0021}));
      repeat (2) @(negedge clk);
      opd_o = 1'b1;
      repeat (3) @(negedge clk);
      opd_o = 1'b0;
      @(negedge clk);
      chk("rd_done", 64'(frame_done), 64'd1);
      chk("rd_fcnt", 64'(frame_cnt), 64'd2);
      repeat (6) @(negedge clk);
      chk("rd_idle", 64'(busy), 64'd0);
      send(16'h0055, 1'b1, 1'b0);
      chk("rd_ignored", 64'(vq.size()), 64'd8);

      // Reset asserted during DRAIN
      run = 1'b1;
      @(negedge clk);
      vq.delete();
      for (int i = 1; i <= 8; i++) send(16'(16'h30 + i), 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      opd_o = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_fcnt", 64'(frame_cnt), 64'd0);
      chk("mrst_errs", 64'({overrun_err, timeout_err}), 64'd0);
      chk("mrst_data", 64'(fft_data), 64'd0);
      chk("mrst_flags", 64'({fft_valid, fft_sop, fft_eop, fft_clr, frame_done}), 64'd0);
      @(negedge clk);
      opd_o = 1'b0;
      rst = 1'b1;
      vq.delete();
      send(16'h0041, 1'b1, 1'b0);
      chk("mrst_sop", 64'(vq.size() > 0 ? vq[0] : 18'h0), 64'({2'b10, 16'h0041}));

      // frame_cnt wrap
      force dut.fcnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.fcnt_q;
      @(negedge clk);
      chk("wrap_pre", 64'(frame_cnt), 64'hFFFF);
      for (int i = 2; i <= 8; i++) send(16'(16'h40 + i), 1'b1, 1'b0);
      chk("wrap_eop", 64'({fft_valid, fft_eop}), 64'h3);
      repeat (2) @(negedge clk);
      opd_o = 1'b1;
      repeat (2) @(negedge clk);
      opd_o = 1'b0;
      @(negedge clk);
      chk("wrap_done", 64'(frame_done), 64'd1);
      chk("wrap_fcnt", 64'(frame_cnt), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
